dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-port data memory slave with a fixed-latency
//                req/ack handshake. Requests are latched in IDLE, held for
//                WAIT_CYCLES wait states, then answered with a one-cycle ack
//                pulse carrying rdata/err. Stores commit on the RESP-entry
//                edge; misaligned or out-of-range requests flag err.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [31:0] rdata_q, rdata_d;

  // Storage is deliberately never reset: contents survive reset pulses.
  logic [31:0] mem [DEPTH_WORDS];

  // Transaction view: with zero wait states the RESP-entry edge is the same
  // edge that accepts the request, so the live inputs must be used there
  // instead of the (not yet loaded) latched copies.
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic             enter_resp;
  logic             mem_wr;

  // Select the transaction operands and decode the error condition.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
    cur_idx = cur_addr[IDX_W+1:2];
    cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:IDX_W+2] != '0);
  end

  // Next-state, latch and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            cnt_d      = 4'd0;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ack_d   = enter_resp;
    err_d   = enter_resp && cur_err;
    rdata_d = (enter_resp && !cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
    busy_d  = (state_d != ST_IDLE);
    mem_wr  = enter_resp && cur_we && !cur_err;
  end

  // State, latched request and registered outputs; reset aborts everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Store commit on the RESP-entry edge; a concurrent reset cancels it.
  always_ff @(posedge clk) begin
    if (!reset && mem_wr) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire
